dbus_ram_timer: RTL and testbench

- Responder on the core's data-memory port; receives the address, write-enable, byte-select, write-data and chip-enable driven by the memory-access stage, and returns read data in the same cycle.
- Hosts a byte-lane-writable word RAM plus a small memory-mapped timer block (counter, compare, control, scratch) that raises a level interrupt.
- Sits at SoC top level between the core data port and the interrupt input.

---
 rtl/dbus_ram_timer.sv | 153 +++++++++++++++
 tb/tb_dbus_ram_timer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_ram_timer.sv
// dbus_ram_timer
//   Data-memory responder for the core: a byte-lane-writable word RAM plus a
//   small memory-mapped timer (TIME, TIMECMP, CTRL, SCRATCH) that drives a
//   level interrupt. Reads are combinational; writes commit on the clock edge.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   mem_addr_i   byte address; addr[31:28]==PERIPH_NIB selects the timer block
//   mem_we_i     1 = write, 0 = read
//   mem_sel_i    byte-lane enables, bit n covers data[8n+7:8n]
//   mem_data_i   write data (already lane-replicated)
//   mem_ce_i     access valid
//   mem_data_o   read data, full word, 0 when not reading or in reset
//   timer_irq_o  registered timer interrupt (pending & enable)
module dbus_ram_timer #(
  parameter int         RAM_AW     = 12,
  parameter logic [3:0] PERIPH_NIB = 4'h4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ce_i,
  output logic [31:0] mem_data_o,
  output logic        timer_irq_o
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  // Address decode
  logic              periph;
  logic [RAM_AW-1:0] ram_idx;
  logic [1:0]        reg_idx;
  logic              wr_en;
  logic              rd_en;
  logic              ram_we;
  logic              time_wr;
  logic              cmp_wr;
  logic              ctrl_wr;
  logic              scratch_wr;

  // Only some address bits are decoded; the rest alias by design.
  logic unused_addr;
  assign unused_addr = ^mem_addr_i;

  assign periph  = (mem_addr_i[31:28] == PERIPH_NIB);
  assign ram_idx = mem_addr_i[RAM_AW+1:2];
  assign reg_idx = mem_addr_i[3:2];
  assign wr_en   = mem_ce_i & mem_we_i;
  assign rd_en   = mem_ce_i & ~mem_we_i;

  // RAM writes must not slip through while reset is held.
  assign ram_we     = wr_en & ~periph & ~rst;
  // A TIME write with no lanes selected is not a write, so counting continues.
  assign time_wr    = wr_en & periph & (reg_idx == 2'd0) & (|mem_sel_i);
  assign cmp_wr     = wr_en & periph & (reg_idx == 2'd1);
  assign ctrl_wr    = wr_en & periph & (reg_idx == 2'd2);
  assign scratch_wr = wr_en & periph & (reg_idx == 2'd3);

  // Word RAM, one byte-wide array per lane
  logic [31:0] ram_rdata;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ram_lane
      logic [7:0] lane_mem [0:RAM_DEPTH-1];

      always_ff @(posedge clk) begin
        if (ram_we && mem_sel_i[gi]) begin
          lane_mem[ram_idx] <= mem_data_i[8*gi +: 8];
        end
      end

      assign ram_rdata[8*gi +: 8] = lane_mem[ram_idx];
    end
  endgenerate

  // Timer registers
  logic [31:0] time_reg;
  logic [31:0] time_next;
  logic [31:0] time_inc;
  logic [31:0] timecmp_reg;
  logic [31:0] timecmp_next;
  logic [31:0] scratch_reg;
  logic [31:0] scratch_next;
  logic        enable_reg;
  logic        enable_next;
  logic        pending_reg;
  logic        pending_next;
  logic        pending_set;
  logic        pending_clr;
  logic        irq_reg;

  assign time_inc = time_reg + 32'd1;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_reg_lane
      // A write freezes the unwritten lanes of TIME for that cycle.
      assign time_next[8*gi +: 8] =
        (time_wr && mem_sel_i[gi]) ? mem_data_i[8*gi +: 8] :
        time_wr                    ? time_reg[8*gi +: 8]   :
                                     time_inc[8*gi +: 8];
      assign timecmp_next[8*gi +: 8] =
        (cmp_wr && mem_sel_i[gi]) ? mem_data_i[8*gi +: 8] : timecmp_reg[8*gi +: 8];
      assign scratch_next[8*gi +: 8] =
        (scratch_wr && mem_sel_i[gi]) ? mem_data_i[8*gi +: 8] : scratch_reg[8*gi +: 8];
    end
  endgenerate

  assign enable_next  = (ctrl_wr && mem_sel_i[0]) ? mem_data_i[0] : enable_reg;
  // Compare uses pre-update values; a set in the same cycle as a W1C wins.
  assign pending_set  = enable_reg & (time_reg == timecmp_reg);
  assign pending_clr  = ctrl_wr & mem_sel_i[0] & mem_data_i[1];
  assign pending_next = pending_set | (pending_reg & ~pending_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_reg    <= 32'd0;
      timecmp_reg <= 32'hFFFF_FFFF;
      scratch_reg <= 32'd0;
      enable_reg  <= 1'b0;
      pending_reg <= 1'b0;
      irq_reg     <= 1'b0;
    end else begin
      time_reg    <= time_next;
      timecmp_reg <= timecmp_next;
      scratch_reg <= scratch_next;
      enable_reg  <= enable_next;
      pending_reg <= pending_next;
      irq_reg     <= pending_reg & enable_reg;
    end
  end

  assign timer_irq_o = irq_reg;

  // Read mux
  logic [31:0] periph_rdata;

  always_comb begin
    periph_rdata = 32'd0;
    case (reg_idx)
      2'd0:    periph_rdata = time_reg;
      2'd1:    periph_rdata = timecmp_reg;
      2'd2:    periph_rdata = {30'd0, pending_reg, enable_reg};
      default: periph_rdata = scratch_reg;
    endcase
  end

  assign mem_data_o = (rd_en && !rst) ? (periph ? periph_rdata : ram_rdata) : 32'd0;

endmodule

// File: tb/tb_dbus_ram_timer.sv
// tb_dbus_ram_timer
//   Directed self-checking bench for dbus_ram_timer. Inputs are driven on the
//   falling edge; outputs are sampled 1 time unit later.
module tb_dbus_ram_timer;

  localparam logic [31:0] A_TIME    = 32'h4000_0000;
  localparam logic [31:0] A_TIMECMP = 32'h4000_0004;
  localparam logic [31:0] A_CTRL    = 32'h4000_0008;
  localparam logic [31:0] A_SCRATCH = 32'h4000_000C;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ce;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  dbus_ram_timer #(
    .RAM_AW    (12),
    .PERIPH_NIB(4'h4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr_i (addr),
    .mem_we_i   (we),
    .mem_sel_i  (sel),
    .mem_data_i (wdata),
    .mem_ce_i   (ce),
    .mem_data_o (rdata),
    .timer_irq_o(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    @(negedge clk);
    addr = a; sel = s; wdata = d; we = 1'b1; ce = 1'b1;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
    $display("wr addr=%h sel=%b data=%h", a, s, d);
  endtask

  task automatic rd(input logic [31:0] a);
    @(negedge clk);
    addr = a; we = 1'b0; ce = 1'b1;
    #1;
    $display("rd addr=%h data=%h irq=%b", a, rdata, irq);
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #3;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want %b", irq, 1'b0); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_timecmp: got %h want %h", rdata, 32'hFFFF_FFFF); end
    rd(A_CTRL);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_ctrl: got %h want %h", rdata, 32'h0); end
    rd(A_SCRATCH);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_scratch: got %h want %h", rdata, 32'h0); end
    // Three rising edges since release -> TIME counted 0,1,2,3
    rd(A_TIME);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL reset_time: got %h want %h", rdata, 32'd3); end
  endtask

  task automatic test_ram_lanes;
    wr(32'h0000_0010, 4'b1111, 32'h1122_3344);
    rd(32'h0000_0010);
    checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL ram_sw: got %h want %h", rdata, 32'h1122_3344); end
    wr(32'h0000_0010, 4'b0100, 32'hAAAA_AAAA);
    rd(32'h0000_0010);
    checks++; if (rdata !== 32'h11AA_3344) begin errors++; $display("FAIL ram_sb: got %h want %h", rdata, 32'h11AA_3344); end
    wr(32'h0000_0010, 4'b0011, 32'hBEEF_BEEF);
    rd(32'h0000_0013);
    checks++; if (rdata !== 32'h11AA_BEEF) begin errors++; $display("FAIL ram_sh: got %h want %h", rdata, 32'h11AA_BEEF); end
    wr(32'h0000_0010, 4'b0000, 32'h0000_0000);
    rd(32'h0000_0010);
    checks++; if (rdata !== 32'h11AA_BEEF) begin errors++; $display("FAIL ram_sel0: got %h want %h", rdata, 32'h11AA_BEEF); end
    wr(32'h0000_0020, 4'b1111, 32'h1234_5678);
    rd(32'h0000_0020);
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_w20: got %h want %h", rdata, 32'h1234_5678); end
  endtask

  task automatic test_alias;
    wr(32'h0000_4000, 4'b1111, 32'hDEAD_BEEF);
    rd(32'h0000_0000);
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias: got %h want %h", rdata, 32'hDEAD_BEEF); end
    rd(32'h0000_0010);
    checks++; if (rdata !== 32'h11AA_BEEF) begin errors++; $display("FAIL ram_alias_other: got %h want %h", rdata, 32'h11AA_BEEF); end
    wr(32'h4ABC_DEFC, 4'b1111, 32'hCAFE_BABE);
    rd(A_SCRATCH);
    checks++; if (rdata !== 32'hCAFE_BABE) begin errors++; $display("FAIL periph_alias: got %h want %h", rdata, 32'hCAFE_BABE); end
    wr(A_SCRATCH, 4'b1000, 32'h0101_0101);
    rd(A_SCRATCH);
    checks++; if (rdata !== 32'h01FE_BABE) begin errors++; $display("FAIL scratch_lane: got %h want %h", rdata, 32'h01FE_BABE); end
  endtask

  task automatic test_irq;
    wr(A_TIMECMP, 4'b1111, 32'd20);
    wr(A_TIME, 4'b1111, 32'd0);      // TIME = 0 after this edge
    wr(A_CTRL, 4'b1111, 32'd1);      // TIME = 1, enable = 1
    idle(19);
    rd(A_TIME);
    checks++; if (rdata !== 32'd20) begin errors++; $display("FAIL irq_time20: got %h want %h", rdata, 32'd20); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_early: got %b want %b", irq, 1'b0); end
    rd(A_CTRL);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL irq_pending: got %h want %h", rdata, 32'd3); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_lag: got %b want %b", irq, 1'b0); end
    rd(A_TIME);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want %b", irq, 1'b1); end
    wr(A_CTRL, 4'b1111, 32'd3);      // W1C pending, keep enable
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_w1c: got %b want %b", irq, 1'b1); end
    rd(A_CTRL);
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL irq_cleared: got %h want %h", rdata, 32'd1); end
    rd(A_CTRL);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want %b", irq, 1'b0); end
  endtask

  task automatic test_set_clear;
    wr(A_TIME, 4'b1111, 32'd100);
    wr(A_TIMECMP, 4'b1111, 32'd101); // TIME becomes 101 on the same edge
    wr(A_CTRL, 4'b1111, 32'd3);      // W1C lands while TIME == TIMECMP
    rd(A_CTRL);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL setclr_pending: got %h want %h", rdata, 32'd3); end
    rd(A_CTRL);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL setclr_irq: got %b want %b", irq, 1'b1); end
  endtask

  task automatic test_mask;
    wr(A_CTRL, 4'b1111, 32'hFFFF_FFFC); // enable=0, no clear, upper bits ignored
    rd(A_CTRL);
    checks++; if (rdata !== 32'd2) begin errors++; $display("FAIL mask_ctrl: got %h want %h", rdata, 32'd2); end
    rd(A_CTRL);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b want %b", irq, 1'b0); end
    wr(A_CTRL, 4'b0001, 32'h0000_0001);
    rd(A_CTRL);
    checks++; if (rdata !== 32'd3) begin errors++; $display("FAIL unmask_ctrl: got %h want %h", rdata, 32'd3); end
    rd(A_CTRL);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL unmask_irq: got %b want %b", irq, 1'b1); end
  endtask

  task automatic test_time_wrap;
    wr(A_TIME, 4'b1111, 32'hFFFF_FFFE);
    rd(A_TIME);
    checks++; if (rdata !== 32'hFFFF_FFFE) begin errors++; $display("FAIL time_written: got %h want %h", rdata, 32'hFFFF_FFFE); end
    rd(A_TIME);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL time_max: got %h want %h", rdata, 32'hFFFF_FFFF); end
    rd(A_TIME);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL time_wrap: got %h want %h", rdata, 32'h0); end
    wr(A_TIME, 4'b0010, 32'h0000_AB00); // TIME was 1; lane 0 frozen
    rd(A_TIME);
    checks++; if (rdata !== 32'h0000_AB01) begin errors++; $display("FAIL time_partial: got %h want %h", rdata, 32'h0000_AB01); end
    rd(A_TIME);
    checks++; if (rdata !== 32'h0000_AB02) begin errors++; $display("FAIL time_resume: got %h want %h", rdata, 32'h0000_AB02); end
    wr(A_TIME, 4'b0000, 32'h0000_0000); // no lanes: keeps counting
    rd(A_TIME);
    checks++; if (rdata !== 32'h0000_AB04) begin errors++; $display("FAIL time_sel0: got %h want %h", rdata, 32'h0000_AB04); end
  endtask

  task automatic test_ce;
    @(negedge clk);
    addr = 32'h0000_0010; we = 1'b0; ce = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ce_low: got %h want %h", rdata, 32'h0); end
    we = 1'b1; ce = 1'b1; sel = 4'b0000;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL ce_write: got %h want %h", rdata, 32'h0); end
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    addr = A_TIMECMP; we = 1'b0; ce = 1'b1;
    #2;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want %b", irq, 1'b1); end
    rst = 1'b1;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want %b", irq, 1'b0); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got %h want %h", rdata, 32'h0); end
    // RAM write attempted across a rising edge while reset is held
    addr = 32'h0000_0020; sel = 4'b1111; wdata = 32'hFFFF_FFFF; we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ce = 1'b0; we = 1'b0; rst = 1'b0;
    rd(32'h0000_0020);
    checks++; if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL reset_ram_wr: got %h want %h", rdata, 32'h1234_5678); end
    rd(A_TIMECMP);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst2_timecmp: got %h want %h", rdata, 32'hFFFF_FFFF); end
    rd(A_CTRL);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst2_ctrl: got %h want %h", rdata, 32'h0); end
    rd(A_SCRATCH);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst2_scratch: got %h want %h", rdata, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst2_irq: got %b want %b", irq, 1'b0); end
  endtask

  initial begin
    rst   = 1'b1;
    addr  = A_TIMECMP;
    we    = 1'b0;
    sel   = 4'b0000;
    wdata = 32'h0;
    ce    = 1'b1;
    test_reset();
    test_ram_lanes();
    test_alias();
    test_irq();
    test_set_clear();
    test_mask();
    test_time_wrap();
    test_ce();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
